// File: rtl/pbs_ctrl_if.sv
// Command/status bundle between the turn sequencer and the battle datapath/UI.
interface pbs_ctrl_if;
  logic       move_valid;
  logic [1:0] move_sel;
  logic [3:0] p_hp;
  logic [3:0] AI_hp;
  logic [1:0] p_move;
  logic       target;
  logic       actr;
  logic       app_dmg;
  logic       calc_dmg;
  logic       busy;
  logic       game_over;
  logic       winner;
  logic [7:0] turn_cnt;

  modport master (
    output move_valid, move_sel, p_hp, AI_hp,
    input  p_move, target, actr, app_dmg, calc_dmg, busy, game_over, winner, turn_cnt
  );

  modport slave (
    input  move_valid, move_sel, p_hp, AI_hp,
    output p_move, target, actr, app_dmg, calc_dmg, busy, game_over, winner, turn_cnt
  );
endinterface

// File: rtl/pbs_ctrl.sv
// Turn sequencer for the battle engine: player attack, faint check,
// AI attack, faint check. All outputs are registered from the next state.
//
// state    | meaning
// IDLE     | waiting for a rising edge on move_valid
// P_SEL    | player attacks AI: select operands
// P_APPLY  | player attacks AI: load AI HP
// P_CALC   | player attacks AI: compute damage
// P_CHK    | AI fainted? (player wins on tie)
// AI_SEL   | AI attacks player: select operands
// AI_APPLY | AI attacks player: load player HP
// AI_CALC  | AI attacks player: compute damage
// AI_CHK   | player fainted? else close the turn
// OVER     | game finished, absorbing until reset
module pbs_ctrl #(
  parameter int PHASE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  pbs_ctrl_if.slave  bus
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] P_SEL    = 4'd1;
  localparam logic [3:0] P_APPLY  = 4'd2;
  localparam logic [3:0] P_CALC   = 4'd3;
  localparam logic [3:0] P_CHK    = 4'd4;
  localparam logic [3:0] AI_SEL   = 4'd5;
  localparam logic [3:0] AI_APPLY = 4'd6;
  localparam logic [3:0] AI_CALC  = 4'd7;
  localparam logic [3:0] AI_CHK   = 4'd8;
  localparam logic [3:0] OVER     = 4'd9;

  localparam logic [3:0] LAST = 4'(PHASE_CYCLES - 1);

  logic [3:0] state, nxt;
  logic [3:0] phase;
  logic       mv_prev;
  logic       start;
  logic       last;
  logic       timed;
  logic       tgt_n, actr_n, app_n, calc_n, busy_n, go_n;

  assign start = bus.move_valid & ~mv_prev;
  assign last  = (phase == LAST);
  assign timed = (state == P_SEL)  || (state == P_APPLY)  || (state == P_CALC) ||
                 (state == AI_SEL) || (state == AI_APPLY) || (state == AI_CALC);

  // Next-state selection; HP is only looked at in the two check states.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (start) nxt = P_SEL;
      P_SEL:    if (last)  nxt = P_APPLY;
      P_APPLY:  if (last)  nxt = P_CALC;
      P_CALC:   if (last)  nxt = P_CHK;
      P_CHK:    nxt = (bus.AI_hp == 4'd0) ? OVER : AI_SEL;
      AI_SEL:   if (last)  nxt = AI_APPLY;
      AI_APPLY: if (last)  nxt = AI_CALC;
      AI_CALC:  if (last)  nxt = AI_CHK;
      AI_CHK:   nxt = (bus.p_hp == 4'd0) ? OVER : IDLE;
      OVER:     nxt = OVER;
      default:  nxt = IDLE;
    endcase
  end

  // Moore output decode of the state being entered, so outputs change on the entering edge.
  always_comb begin
    tgt_n  = 1'b0;
    actr_n = 1'b0;
    app_n  = 1'b0;
    calc_n = 1'b0;
    busy_n = 1'b1;
    go_n   = 1'b0;
    case (nxt)
      IDLE:     busy_n = 1'b0;
      P_SEL:    tgt_n  = 1'b1;
      P_APPLY:  begin tgt_n = 1'b1; app_n  = 1'b1; end
      P_CALC:   begin tgt_n = 1'b1; calc_n = 1'b1; end
      AI_SEL:   actr_n = 1'b1;
      AI_APPLY: begin actr_n = 1'b1; app_n  = 1'b1; end
      AI_CALC:  begin actr_n = 1'b1; calc_n = 1'b1; end
      OVER:     begin busy_n = 1'b0; go_n = 1'b1; end
      default:  ;
    endcase
  end

  // Button history for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mv_prev <= 1'b0;
    else     mv_prev <= bus.move_valid;
  end

  // State register and phase counter; the counter restarts on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      phase <= 4'd0;
    end else begin
      state <= nxt;
      if ((nxt != state) || !timed) phase <= 4'd0;
      else                          phase <= phase + 4'd1;
    end
  end

  // Registered command/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.target    <= 1'b0;
      bus.actr      <= 1'b0;
      bus.app_dmg   <= 1'b0;
      bus.calc_dmg  <= 1'b0;
      bus.busy      <= 1'b0;
      bus.game_over <= 1'b0;
    end else begin
      bus.target    <= tgt_n;
      bus.actr      <= actr_n;
      bus.app_dmg   <= app_n;
      bus.calc_dmg  <= calc_n;
      bus.busy      <= busy_n;
      bus.game_over <= go_n;
    end
  end

  // Move latch, winner flag and saturating turn counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.p_move   <= 2'd0;
      bus.winner   <= 1'b0;
      bus.turn_cnt <= 8'd0;
    end else begin
      if (state == IDLE && start) bus.p_move <= bus.move_sel;
      if (state == P_CHK  && nxt == OVER) bus.winner <= 1'b0;
      if (state == AI_CHK && nxt == OVER) bus.winner <= 1'b1;
      if (state == AI_CHK && nxt == IDLE && bus.turn_cnt != 8'hFF)
        bus.turn_cnt <= bus.turn_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_pbs_ctrl.sv
// Bench for pbs_ctrl: two instances (PHASE_CYCLES 2 and 1), per-cycle expected
// output words queued from a timing model and compared as the DUT runs.
module tb_pbs_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pbs_ctrl_if if_a();
  pbs_ctrl_if if_b();

  pbs_ctrl #(.PHASE_CYCLES(2)) u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  pbs_ctrl #(.PHASE_CYCLES(1)) u_b (.clk(clk), .rst(rst), .bus(if_b.slave));

  // word bits: {game_over, busy, target, actr, app_dmg, calc_dmg}
  localparam logic [5:0] W_IDLE   = 6'b000000;
  localparam logic [5:0] W_PSEL   = 6'b011000;
  localparam logic [5:0] W_PAPP   = 6'b011010;
  localparam logic [5:0] W_PCALC  = 6'b011001;
  localparam logic [5:0] W_CHK    = 6'b010000;
  localparam logic [5:0] W_ASEL   = 6'b010100;
  localparam logic [5:0] W_AAPP   = 6'b010110;
  localparam logic [5:0] W_ACALC  = 6'b010101;
  localparam logic [5:0] W_OVER   = 6'b100000;
  localparam logic [5:0] M_ALL    = 6'b111111;
  localparam logic [5:0] M_CHK    = 6'b110011;

  typedef struct {
    logic [5:0] w;
    logic [5:0] m;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] word_of(input int p);
    if (p == 2)
      return {if_a.game_over, if_a.busy, if_a.target, if_a.actr, if_a.app_dmg, if_a.calc_dmg};
    else
      return {if_b.game_over, if_b.busy, if_b.target, if_b.actr, if_b.app_dmg, if_b.calc_dmg};
  endfunction

  // Expected word sampled after edge k+j, where edge k captured the start edge.
  function automatic exp_t model(input int p, input int j, input bit ai_ko, input bit p_ko);
    exp_t e;
    int   i;
    e.m = M_ALL;
    if      (j < p)     e.w = W_PSEL;
    else if (j < 2*p)   e.w = W_PAPP;
    else if (j < 3*p)   e.w = W_PCALC;
    else if (j == 3*p)  begin e.w = W_CHK; e.m = M_CHK; end
    else if (ai_ko)     e.w = W_OVER;
    else begin
      i = j - (3*p + 1);
      if      (i < p)     e.w = W_ASEL;
      else if (i < 2*p)   e.w = W_AAPP;
      else if (i < 3*p)   e.w = W_ACALC;
      else if (i == 3*p)  begin e.w = W_CHK; e.m = M_CHK; end
      else                e.w = p_ko ? W_OVER : W_IDLE;
    end
    return e;
  endfunction

  task automatic set_mv(input int p, input logic v);
    if (p == 2) if_a.move_valid = v; else if_b.move_valid = v;
  endtask

  task automatic set_sel(input int p, input logic [1:0] s);
    if (p == 2) if_a.move_sel = s; else if_b.move_sel = s;
  endtask

  task automatic set_hp(input int p, input logic [3:0] ph, input logic [3:0] ah);
    if (p == 2) begin if_a.p_hp = ph; if_a.AI_hp = ah; end
    else        begin if_b.p_hp = ph; if_b.AI_hp = ah; end
  endtask

  // Called at a negedge with move_valid low; raises it and tracks n cycles.
  task automatic run_turn(input int p, input logic [1:0] sel, input bit ai_ko, input bit p_ko,
                          input int n, input bit hold, input string name);
    exp_t e;
    for (int j = 0; j < n; j++) begin
      e = model(p, j, ai_ko, p_ko);
      e.tag = $sformatf("%s_c%0d", name, j);
      sb.push_back(e);
    end
    set_sel(p, sel);
    set_mv(p, 1'b1);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      if (j == 0 && !hold) set_mv(p, 1'b0);
      e = sb.pop_front();
      check_val(e.tag, word_of(p) & e.m, e.w & e.m);
    end
  endtask

  task automatic expect_const(input int p, input logic [5:0] w, input int n, input string name);
    exp_t e;
    for (int j = 0; j < n; j++) begin
      e.w = w; e.m = M_ALL; e.tag = $sformatf("%s_c%0d", name, j);
      sb.push_back(e);
    end
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      e = sb.pop_front();
      check_val(e.tag, word_of(p), e.w);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_mv(2, 1'b0); set_mv(1, 1'b0);
    set_sel(2, 2'b00); set_sel(1, 2'b00);
    set_hp(2, 4'hA, 4'hA); set_hp(1, 4'hA, 4'hA);
    #3;
    check_val("rst_word_a", word_of(2), W_IDLE);
    check_val("rst_word_b", word_of(1), W_IDLE);
    check_val("rst_turn_cnt", if_a.turn_cnt, 8'd0);
    check_val("rst_p_move", if_a.p_move, 2'd0);
    check_val("rst_winner", if_a.winner, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    expect_const(2, W_IDLE, 20, "idle");
    check_val("idle_turn_cnt", if_a.turn_cnt, 8'd0);

    // normal turn
    run_turn(2, 2'b10, 1'b0, 1'b0, 15, 1'b0, "norm");
    check_val("norm_p_move", if_a.p_move, 2'd2);
    check_val("norm_turn_cnt", if_a.turn_cnt, 8'd1);

    // button held 40 cycles: one turn only
    run_turn(2, 2'b11, 1'b0, 1'b0, 40, 1'b1, "hold");
    check_val("hold_turn_cnt", if_a.turn_cnt, 8'd2);
    check_val("hold_p_move", if_a.p_move, 2'd3);
    set_mv(2, 1'b0);
    @(negedge clk);

    // mid-turn async reset during AI_APPLY (sample 9 is AI_APPLY for 2-cycle phases)
    run_turn(2, 2'b01, 1'b0, 1'b0, 10, 1'b0, "mid");
    #2 rst = 1'b1;
    #1;
    check_val("mid_rst_word", word_of(2), W_IDLE);
    check_val("mid_rst_app_dmg", if_a.app_dmg, 1'b0);
    check_val("mid_rst_turn_cnt", if_a.turn_cnt, 8'd0);
    check_val("mid_rst_p_move", if_a.p_move, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    expect_const(2, W_IDLE, 3, "post_rst");

    // AI knocks out the player: turn_cnt keeps its value
    run_turn(2, 2'b00, 1'b0, 1'b0, 15, 1'b0, "pre");
    set_hp(2, 4'h0, 4'h5);
    run_turn(2, 2'b01, 1'b0, 1'b1, 18, 1'b0, "pko");
    check_val("pko_winner", if_a.winner, 1'b1);
    check_val("pko_game_over", if_a.game_over, 1'b1);
    check_val("pko_turn_cnt", if_a.turn_cnt, 8'd1);

    // player knocks out the AI: OVER after k+7, further presses ignored
    do_reset();
    set_hp(2, 4'hA, 4'h0);
    run_turn(2, 2'b10, 1'b1, 1'b0, 12, 1'b0, "aiko");
    check_val("aiko_winner", if_a.winner, 1'b0);
    check_val("aiko_turn_cnt", if_a.turn_cnt, 8'd0);
    set_sel(2, 2'b01);
    set_mv(2, 1'b1);
    expect_const(2, W_OVER, 6, "aiko_press");
    set_mv(2, 1'b0);
    check_val("aiko_p_move_kept", if_a.p_move, 2'd2);
    check_val("aiko_winner_kept", if_a.winner, 1'b0);

    // both sides at zero: player check comes first
    do_reset();
    set_hp(2, 4'h0, 4'h0);
    run_turn(2, 2'b11, 1'b1, 1'b0, 10, 1'b0, "tie");
    check_val("tie_winner", if_a.winner, 1'b0);

    // saturation with 1-cycle phases: 8-cycle turns, counter stops at 255
    do_reset();
    for (int t = 0; t < 260; t++) begin
      run_turn(1, 2'(t), 1'b0, 1'b0, 9, 1'b0, $sformatf("sat%0d", t));
      check_val($sformatf("sat%0d_turn_cnt", t), if_b.turn_cnt, (t + 1 > 255) ? 255 : t + 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/pbs_ctrl.md
# pbs_ctrl

Turn-sequencing controller for the battle engine. It sits directly upstream of the battle datapath and drives that datapath's `target`, `p_move`, `actr`, `calc_dmg` and `app_dmg` inputs. It reads back `p_hp` and `AI_hp` to decide when a side has fainted. Each player button press runs one full turn: the player attacks the AI, a faint check follows, the AI attacks the player, and a second faint check closes the turn.

## Interface
- `PHASE_CYCLES`, default 2: cycles each command phase is held; legal range 1–15.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `move_valid`  in  1  player confirm button, level; only a rising edge starts a turn.
- `move_sel`  in  2  player move choice; sampled on the start edge only.
- `p_hp`  in  4  player HP from the datapath; 0 means fainted.
- `AI_hp`  in  4  AI HP from the datapath; 0 means fainted.
- `p_move`  out  2  latched player move.
- `target`  out  1  side being hit: 1 = AI, 0 = player.
- `actr`  out  1  attacker select: 0 = player move, 1 = AI random move.
- `app_dmg`  out  1  load the target's current HP.
- `calc_dmg`  out  1  enable the damage computation.
- `busy`  out  1  high in every state except IDLE and OVER.
- `game_over`  out  1  high in OVER.
- `winner`  out  1  0 = player won, 1 = AI won; valid only while `game_over` is high.
- `turn_cnt`  out  8  completed turns, saturating.

## Operation
- All outputs are registered and Moore-decoded. Each output takes its new-state value on the same edge that enters the state.
- Reset (async) sets: state IDLE, `mv_prev`=0, `p_move`=0, `target`=0, `actr`=0, `app_dmg`=0, `calc_dmg`=0, `busy`=0, `game_over`=0, `winner`=0, `turn_cnt`=0, phase counter=0.
- `mv_prev` registers `move_valid` every cycle. The start condition is `move_valid & ~mv_prev` while in IDLE. Edges in any other state are ignored and are not queued.
- Phase counter counts 0..PHASE_CYCLES-1 inside each timed state. It clears on every state change.
- States and outputs:
  - IDLE: all strobes 0. On the start condition, latch `p_move`←`move_sel` and go to P_SEL.
  - P_SEL: `target`=1, `actr`=0.
  - P_APPLY: `target`=1, `actr`=0, `app_dmg`=1.
  - P_CALC: `target`=1, `actr`=0, `calc_dmg`=1.
  - P_CHK (1 cycle): if `AI_hp`==0, set `winner`=0 and go to OVER; else go to AI_SEL.
  - AI_SEL: `target`=0, `actr`=1.
  - AI_APPLY: `target`=0, `actr`=1, `app_dmg`=1.
  - AI_CALC: `target`=0, `actr`=1, `calc_dmg`=1.
  - AI_CHK (1 cycle): if `p_hp`==0, set `winner`=1 and go to OVER; else increment `turn_cnt` (saturate at 255) and go to IDLE.
  - OVER: `game_over`=1, all strobes 0. OVER is absorbing until `rst`.
- Timed states are P_SEL, P_APPLY, P_CALC, AI_SEL, AI_APPLY and AI_CALC. Each advances when the phase counter reaches PHASE_CYCLES-1.
- `app_dmg` and `calc_dmg` are never high together. Neither strobe is high during any SEL or CHK state.
- `p_move` holds its latched value until the next start edge, including through OVER.
- HP inputs are sampled only in the CHK states. Zero HP seen anywhere else has no effect.
- If both HPs read 0, P_CHK is reached first, so the player wins.

## Timing
- Start edge sampled at clock edge k: outputs for P_SEL are visible after edge k.
- A full non-final turn takes 6·PHASE_CYCLES+2 cycles. With the default that is 14, so the controller is back in IDLE with `busy`=0 after edge k+14.
- `turn_cnt` updates on the edge leaving AI_CHK.
- With PHASE_CYCLES=2, AI KO is detected in P_CHK (after edge k+6). OVER is entered after edge k+7.
- A new turn needs a fresh rising edge after IDLE is re-entered. A button held high through the turn does not retrigger.
- `rst` asserted mid-turn forces all outputs to their reset values immediately, without waiting for a clock. The in-flight turn is abandoned.

## Test plan
- Reset then idle: `rst`=1, then release; no `move_valid` edge → all outputs 0 and `busy`=0 for 20 cycles.
- Normal turn: `move_sel`=2'b10, pulse `move_valid`, HP inputs held at 4'hA → `p_move`=2, `app_dmg` high for exactly 2 cycles with `target`=1, then `calc_dmg` for 2 cycles, then the mirror phases with `target`=0 and `actr`=1; IDLE after 14 cycles; `turn_cnt`=1.
- Player KO of AI: `AI_hp`=0 before P_CHK → `game_over`=1 and `winner`=0 at k+7; the AI phases never assert; further presses are ignored.
- AI KO of player: `p_hp`=0 and `AI_hp`=5 → `game_over`=1 and `winner`=1 after AI_CHK; `turn_cnt` is unchanged.
- Held button plus mid-turn reset: hold `move_valid`=1 for 40 cycles → exactly one turn runs. Assert `rst` during AI_APPLY → strobes drop to 0 asynchronously and the state returns to IDLE.
- Saturation and parameter: run 260 turns with PHASE_CYCLES=1 → each turn lasts 8 cycles and `turn_cnt` stops at 255.
